// File: rtl/nios_security_pkg.sv
// Shared definitions for the security RAM fill/verify engine: FSM states,
// CSR word offsets and CSR bit positions.
package nios_security_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DRAIN  = 2'd3
  } bist_state_e;

  localparam logic [1:0] CSR_CTRL    = 2'd0;
  localparam logic [1:0] CSR_STATUS  = 2'd1;
  localparam logic [1:0] CSR_PATTERN = 2'd2;
  localparam logic [1:0] CSR_RESULT  = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_MODE   = 2;
  localparam int CTRL_VERIFY = 3;
  localparam int CTRL_IRQEN  = 4;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_FAIL    = 2;
  localparam int STAT_ABORTED = 3;

  localparam int RES_ADDR_LSB = 16;
  localparam int RES_VALID    = 31;

endpackage

// File: rtl/nios_security_ram_bist_csr.sv
// CSR block of the RAM fill/verify engine: control/pattern registers,
// start/abort pulse decode, sticky done/aborted flags and the readdata mux.
module nios_security_ram_bist_csr
  import nios_security_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic              busy_i,
  input  logic              fail_i,
  input  logic              done_set_i,
  input  logic [ERR_W-1:0]  errcnt_i,
  input  logic [ADDR_W-1:0] ff_addr_i,
  input  logic              ff_vld_i,
  output logic              start_o,
  output logic              abort_o,
  output logic              start_mode_o,
  output logic              start_ver_o,
  output logic [DATA_W-1:0] pattern_o,
  output logic              irq_o
);

  logic              mode_q, mode_d;
  logic              ver_q, ver_d;
  logic              irqen_q, irqen_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ctrl_wr, stat_wr, pat_wr;
  logic              unused_wdata;

  assign unused_wdata = ^csr_writedata;

  assign ctrl_wr = csr_write && (csr_address == CSR_CTRL);
  assign stat_wr = csr_write && (csr_address == CSR_STATUS);
  assign pat_wr  = csr_write && (csr_address == CSR_PATTERN);

  // Abort beats a start in the same write; both only act in the right FSM phase.
  assign start_o      = ctrl_wr && csr_writedata[CTRL_START] && !csr_writedata[CTRL_ABORT] && !busy_i;
  assign abort_o      = ctrl_wr && csr_writedata[CTRL_ABORT] && busy_i;
  assign start_mode_o = csr_writedata[CTRL_MODE];
  assign start_ver_o  = csr_writedata[CTRL_VERIFY];

  always_comb begin
    mode_d    = mode_q;
    ver_d     = ver_q;
    irqen_d   = irqen_q;
    pat_d     = pat_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    if (ctrl_wr) begin
      ver_d   = csr_writedata[CTRL_VERIFY];
      irqen_d = csr_writedata[CTRL_IRQEN];
      if (!busy_i) mode_d = csr_writedata[CTRL_MODE];
    end
    if (pat_wr && !busy_i) pat_d = csr_writedata[DATA_W-1:0];
    // Completion set has priority over a W1C landing on the same edge.
    if (done_set_i)                                    done_d = 1'b1;
    else if (start_o || abort_o)                       done_d = 1'b0;
    else if (stat_wr && csr_writedata[STAT_DONE])      done_d = 1'b0;
    if (abort_o)                                       aborted_d = 1'b1;
    else if (start_o)                                  aborted_d = 1'b0;
    else if (stat_wr && csr_writedata[STAT_ABORTED])   aborted_d = 1'b0;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (csr_read) begin
      rdata_d = '0;
      case (csr_address)
        CSR_CTRL: begin
          rdata_d[CTRL_MODE]   = mode_q;
          rdata_d[CTRL_VERIFY] = ver_q;
          rdata_d[CTRL_IRQEN]  = irqen_q;
        end
        CSR_STATUS: begin
          rdata_d[STAT_BUSY]    = busy_i;
          rdata_d[STAT_DONE]    = done_q;
          rdata_d[STAT_FAIL]    = fail_i;
          rdata_d[STAT_ABORTED] = aborted_q;
        end
        CSR_PATTERN: rdata_d = 32'(pat_q);
        default: begin
          rdata_d[ERR_W-1:0]               = errcnt_i;
          rdata_d[RES_ADDR_LSB +: ADDR_W] = ff_addr_i;
          rdata_d[RES_VALID]               = ff_vld_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= 1'b0;
      ver_q     <= 1'b0;
      irqen_q   <= 1'b0;
      pat_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      ver_q     <= ver_d;
      irqen_q   <= irqen_d;
      pat_q     <= pat_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      rdata_q   <= rdata_d;
    end
  end

  assign csr_readdata = rdata_q;
  assign pattern_o    = pat_q;
  assign irq_o        = done_q && irqen_q;

endmodule

// File: rtl/nios_security_ram_bist.sv
// Security RAM fill/verify engine: writes every RAM word with a pattern, optionally
// reads it all back through a 1-cycle compare pipeline and records errors.
module nios_security_ram_bist
  import nios_security_pkg::*;
#(
  parameter int DEPTH  = 32768,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  output logic [31:0]         csr_readdata,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                ram_clken,
  output logic                irq
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] op_pat_q;
  logic              op_mode_q, op_ver_q;
  logic              cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [DATA_W-1:0] cmp_exp_q;
  logic [ERR_W-1:0]  errcnt_q, errcnt_d;
  logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
  logic              ff_vld_q, ff_vld_d;
  logic              fail_q, fail_d;

  logic              busy, last, done_set, mismatch;
  logic              start, abort, start_mode, start_ver;
  logic [DATA_W-1:0] pattern, exp_data;

  nios_security_ram_bist_csr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .ERR_W  (ERR_W)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .busy_i        (busy),
    .fail_i        (fail_q),
    .done_set_i    (done_set),
    .errcnt_i      (errcnt_q),
    .ff_addr_i     (ff_addr_q),
    .ff_vld_i      (ff_vld_q),
    .start_o       (start),
    .abort_o       (abort),
    .start_mode_o  (start_mode),
    .start_ver_o   (start_ver),
    .pattern_o     (pattern),
    .irq_o         (irq)
  );

  assign busy     = (state_q != ST_IDLE);
  assign last     = (addr_q == LAST);
  assign exp_data = op_mode_q ? (op_pat_q ^ DATA_W'(addr_q)) : op_pat_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    done_set = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FILL;
        addr_d  = '0;
      end
      ST_FILL: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last) begin
          addr_d = '0;
          if (op_ver_q) state_d = ST_VERIFY;
          else begin
            state_d  = ST_IDLE;
            done_set = 1'b1;
          end
        end
      end
      ST_VERIFY: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last) begin
          addr_d  = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d  = ST_IDLE;
        done_set = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      addr_d   = '0;
      done_set = 1'b0;
    end
  end

  // Readdata for the word addressed last cycle is checked against the delayed expectation.
  assign cmp_vld_d = (state_q == ST_VERIFY) && !abort;
  assign mismatch  = cmp_vld_q && (ram_readdata != cmp_exp_q) && !abort;

  always_comb begin
    errcnt_d  = errcnt_q;
    ff_addr_d = ff_addr_q;
    ff_vld_d  = ff_vld_q;
    fail_d    = fail_q;
    if (start) begin
      errcnt_d  = '0;
      ff_addr_d = '0;
      ff_vld_d  = 1'b0;
      fail_d    = 1'b0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (errcnt_q != '1) errcnt_d = errcnt_q + ERR_W'(1);
      if (!ff_vld_q) begin
        ff_vld_d  = 1'b1;
        ff_addr_d = cmp_addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      op_pat_q   <= '0;
      op_mode_q  <= 1'b0;
      op_ver_q   <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      cmp_exp_q  <= '0;
      errcnt_q   <= '0;
      ff_addr_q  <= '0;
      ff_vld_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_addr_q <= addr_q;
      cmp_exp_q  <= exp_data;
      errcnt_q   <= errcnt_d;
      ff_addr_q  <= ff_addr_d;
      ff_vld_q   <= ff_vld_d;
      fail_q     <= fail_d;
      if (start) begin
        op_pat_q  <= pattern;
        op_mode_q <= start_mode;
        op_ver_q  <= start_ver;
      end
    end
  end

  assign ram_chipselect = (state_q == ST_FILL) || (state_q == ST_VERIFY);
  assign ram_write      = (state_q == ST_FILL);
  assign ram_address    = addr_q;
  assign ram_writedata  = ram_write ? exp_data : '0;
  assign ram_byteenable = {(DATA_W/8){1'b1}};
  assign ram_clken      = 1'b1;

endmodule

// File: tb/tb_nios_security_ram_bist.sv
// Directed bench for the security RAM fill/verify engine with a 1-cycle-latency
// RAM model; expected RAM traffic is queued at start and popped by a monitor.
module tb_nios_security_ram_bist;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int EW    = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    csr_address = '0;
  logic          csr_read = 1'b0;
  logic          csr_write = 1'b0;
  logic [31:0]   csr_writedata = '0;
  logic [31:0]   csr_readdata;
  logic [AW-1:0] ram_address;
  logic          ram_chipselect, ram_write, ram_clken, irq;
  logic [3:0]    ram_byteenable;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata = '0;

  nios_security_ram_bist #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .ERR_W(EW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata),
    .ram_clken      (ram_clken),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] corrupt = '0;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) mem[ram_address] <= ram_writedata;
      ram_readdata <= mem[ram_address] ^ (corrupt[ram_address] ? 32'hDEAD_0000 : 32'h0);
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  wr_t           mon_e;
  logic [AW-1:0] mon_a;
  int            checks = 0;
  int            failures = 0;
  int            t0 = 0;
  logic [31:0]   rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM access must match the next queued expectation.
  always @(negedge clk) begin
    if (reset_n && ram_chipselect) begin
      check("byteenable", 64'(ram_byteenable), 64'hF);
      if (ram_write) begin
        if (wq.size() == 0) check("wr_unexpected", 64'(ram_address), 64'hFFFF);
        else begin
          mon_e = wq.pop_front();
          check("wr_addr", 64'(ram_address), 64'(mon_e.a));
          check("wr_data", 64'(ram_writedata), 64'(mon_e.d));
        end
      end else begin
        if (rq.size() == 0) check("rd_unexpected", 64'(ram_address), 64'hFFFF);
        else begin
          mon_a = rq.pop_front();
          check("rd_addr", 64'(ram_address), 64'(mon_a));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    tick(1);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    tick(1);
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic push_op(input logic [31:0] pat, input bit mode, input bit ver);
    for (int i = 0; i < DEPTH; i++) begin
      wq.push_back('{a: AW'(i), d: mode ? (pat ^ 32'(i)) : pat});
      if (ver) rq.push_back(AW'(i));
    end
  endtask

  task automatic start_op(input logic [31:0] ctrl, input logic [31:0] pat);
    push_op(pat, ctrl[2], ctrl[3]);
    t0 = cyc;
    csr_wr(2'd0, ctrl);
  endtask

  task automatic wait_done(input string tag, input int exp_dt);
    int n = 0;
    while (irq !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, 64'(cyc - t0), 64'(exp_dt));
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_wq"}, 64'(wq.size()), 64'd0);
    check({tag, "_rq"}, 64'(rq.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},    64'(ram_chipselect), 64'd0);
    check({tag, "_we"},    64'(ram_write), 64'd0);
    check({tag, "_addr"},  64'(ram_address), 64'd0);
    check({tag, "_wdata"}, 64'(ram_writedata), 64'd0);
    check({tag, "_be"},    64'(ram_byteenable), 64'hF);
    check({tag, "_clken"}, 64'(ram_clken), 64'd1);
    check({tag, "_irq"},   64'(irq), 64'd0);
    check({tag, "_rdata"}, 64'(csr_readdata), 64'd0);
  endtask

  initial begin
    // Reset values
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(1);
    csr_rd(2'd1, rd); check("reset_status", 64'(rd), 64'h0);
    csr_rd(2'd3, rd); check("reset_result", 64'(rd), 64'h0);

    // Zeroize with verify
    csr_wr(2'd2, 32'h0);
    start_op(32'h19, 32'h0);
    wait_done("zero_done_dt", 34);
    csr_rd(2'd1, rd); check("zero_status", 64'(rd), 64'h2);
    csr_rd(2'd3, rd); check("zero_result", 64'(rd), 64'h0);
    check_queues_empty("zero");
    csr_wr(2'd1, 32'h2);
    check("w1c_irq_drop", 64'(irq), 64'd0);

    // Address-xor mode
    csr_wr(2'd2, 32'hA5A5_0000);
    start_op(32'h1D, 32'hA5A5_0000);
    wait_done("xor_done_dt", 34);
    check("xor_word7", 64'(mem[7]), 64'hA5A5_0007);
    csr_rd(2'd1, rd); check("xor_status", 64'(rd), 64'h2);
    csr_rd(2'd3, rd); check("xor_result", 64'(rd), 64'h0);
    csr_rd(2'd2, rd); check("xor_pattern", 64'(rd), 64'hA5A5_0000);
    check_queues_empty("xor");

    // Read corruption on words 3 and 9
    corrupt = 16'h0208;
    csr_wr(2'd2, 32'h1234_5678);
    start_op(32'h19, 32'h1234_5678);
    wait_done("bad_done_dt", 34);
    csr_rd(2'd1, rd); check("bad_status", 64'(rd), 64'h6);
    csr_rd(2'd3, rd); check("bad_result", 64'(rd), 64'h8003_0002);
    check_queues_empty("bad");
    corrupt = '0;

    // Abort at T+5, then a normal restart
    start_op(32'h19, 32'h1234_5678);
    tick(4);
    csr_wr(2'd0, 32'h1A);
    check("abort_cs", 64'(ram_chipselect), 64'd0);
    check("abort_writes_left", 64'(wq.size()), 64'd11);
    check("abort_reads_left", 64'(rq.size()), 64'd16);
    wq.delete();
    rq.delete();
    csr_rd(2'd1, rd); check("abort_status", 64'(rd), 64'h8);
    check("abort_irq", 64'(irq), 64'd0);
    start_op(32'h19, 32'h1234_5678);
    wait_done("restart_done_dt", 34);
    csr_rd(2'd1, rd); check("restart_status", 64'(rd), 64'h2);
    check_queues_empty("restart");

    // Start and PATTERN rewritten while busy are ignored
    csr_wr(2'd2, 32'h0F0F_0F0F);
    start_op(32'h19, 32'h0F0F_0F0F);
    tick(2);
    csr_wr(2'd0, 32'h19);
    csr_wr(2'd2, 32'hFFFF_FFFF);
    csr_rd(2'd2, rd); check("busy_pattern", 64'(rd), 64'h0F0F_0F0F);
    csr_rd(2'd1, rd); check("busy_status", 64'(rd), 64'h1);
    wait_done("rewrite_done_dt", 34);
    check_queues_empty("rewrite");

    // Start+abort together from IDLE starts nothing
    csr_wr(2'd1, 32'h2);
    csr_wr(2'd0, 32'h1B);
    tick(3);
    check("startabort_cs", 64'(ram_chipselect), 64'd0);
    csr_rd(2'd1, rd); check("startabort_status", 64'(rd[2:0]), 64'h0);

    // Fill only, IRQ timing and W1C
    csr_wr(2'd2, 32'h5555_AAAA);
    start_op(32'h11, 32'h5555_AAAA);
    wait_done("fill_done_dt", 17);
    check("fill_irq", 64'(irq), 64'd1);
    csr_rd(2'd1, rd); check("fill_status", 64'(rd), 64'h2);
    csr_rd(2'd0, rd); check("fill_ctrl", 64'(rd), 64'h10);
    check_queues_empty("fill");
    csr_wr(2'd1, 32'h2);
    check("fill_irq_w1c", 64'(irq), 64'd0);

    // Reset mid-FILL
    start_op(32'h11, 32'h5555_AAAA);
    tick(3);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    wq.delete();
    rq.delete();
    #10;
    reset_n = 1'b1;
    tick(1);
    csr_rd(2'd0, rd); check("midreset_ctrl", 64'(rd), 64'h0);
    csr_rd(2'd2, rd); check("midreset_pattern", 64'(rd), 64'h0);
    csr_rd(2'd1, rd); check("midreset_status", 64'(rd), 64'h0);
    tick(2);
    check("midreset_idle_cs", 64'(ram_chipselect), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
